// File: rtl/pipe_ctrl.sv
// Hazard, forwarding and memory-wait controller for a classic 5-stage pipeline.
// Owns the stage-valid bits, the data-memory timeout FSM and two saturating performance counters.
module pipe_ctrl #(
    parameter int AW          = 5,
    parameter int FLUSH_DEPTH = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             redirect,
    input  logic [AW-1:0]    ex_rs,
    input  logic [AW-1:0]    ex_rt,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [AW-1:0]    wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_id_a,
    output logic             fwd_id_b,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             halted_q, halted_d;
    logic             v_id_q, v_id_d, v_ex_q, v_ex_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
    logic [CNT_W-1:0] retired_q, retired_d, stall_q, stall_d;

    logic load_use, branch_stall, mem_wait_run, mem_stall, hz_stall, redir_ok;
    logic flush_if, flush_ex;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [AW-1:0] dst, input logic prod_ok,
                                 input logic [AW-1:0] src, input logic used);
        return (dst != '0) && prod_ok && used && (dst == src);
    endfunction

    always_comb begin
        load_use = hit(ex_rd, v_ex_q & ex_memread, id_rs, id_uses_rs)
                 | hit(ex_rd, v_ex_q & ex_memread, id_rt, id_uses_rt);
        branch_stall = (FLUSH_DEPTH == 1) && id_is_branch &&
                       (hit(ex_rd, v_ex_q & ex_regwrite, id_rs, id_uses_rs)
                      | hit(ex_rd, v_ex_q & ex_regwrite, id_rt, id_uses_rt)
                      | hit(mem_rd, v_mem_q & mem_memread, id_rs, id_uses_rs)
                      | hit(mem_rd, v_mem_q & mem_memread, id_rt, id_uses_rt));
        mem_wait_run = (state_q == RUN) && v_mem_q && mem_req && !dmem_ready;
        mem_stall    = (state_q == HALT) || mem_wait_run || ((state_q == MEM_WAIT) && !dmem_ready);
        hz_stall     = !mem_stall && (load_use || branch_stall);
        redir_ok     = !mem_stall && !hz_stall && redirect;
        flush_if     = redir_ok;
        flush_ex     = hz_stall || (redir_ok && (FLUSH_DEPTH == 2));
    end

    // Every control output is forced quiet while reset is held.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_flush = 1'b0;
        fwd_a        = 2'd0;
        fwd_b        = 2'd0;
        fwd_id_a     = 1'b0;
        fwd_id_b     = 1'b0;
        if (reset) begin
            pc_hold      = mem_stall || hz_stall;
            if_id_hold   = mem_stall || hz_stall;
            if_id_flush  = flush_if;
            id_ex_hold   = mem_stall;
            id_ex_flush  = flush_ex;
            ex_mem_hold  = mem_stall;
            mem_wb_flush = mem_stall;
            if (hit(mem_rd, v_mem_q & mem_regwrite, ex_rs, 1'b1))
                fwd_a = 2'd2;
            else if (hit(wb_rd, v_wb_q & wb_regwrite, ex_rs, 1'b1))
                fwd_a = 2'd1;
            if (hit(mem_rd, v_mem_q & mem_regwrite, ex_rt, 1'b1))
                fwd_b = 2'd2;
            else if (hit(wb_rd, v_wb_q & wb_regwrite, ex_rt, 1'b1))
                fwd_b = 2'd1;
            fwd_id_a = hit(mem_rd, v_mem_q & mem_regwrite & ~mem_memread, id_rs, id_uses_rs);
            fwd_id_b = hit(mem_rd, v_mem_q & mem_regwrite & ~mem_memread, id_rt, id_uses_rt);
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        halted_d   = halted_q;
        case (state_q)
            RUN: begin
                if (mem_wait_run) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HALT: begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (mem_stall) begin
            v_id_d  = v_id_q;
            v_ex_d  = v_ex_q;
            v_mem_d = v_mem_q;
            v_wb_d  = 1'b0;
        end else if (hz_stall) begin
            v_id_d  = v_id_q;
            v_ex_d  = 1'b0;
            v_mem_d = v_ex_q;
            v_wb_d  = v_mem_q;
        end else begin
            v_id_d  = fetch_valid && !flush_if;
            v_ex_d  = v_id_q && !flush_ex;
            v_mem_d = v_ex_q;
            v_wb_d  = v_mem_q;
        end

        retired_d = retired_q;
        if (v_wb_q && (state_q != HALT) && (retired_q != '1))
            retired_d = retired_q + 1'b1;
        stall_d = stall_q;
        if ((mem_stall || hz_stall) && (state_q != HALT) && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            v_id_q     <= 1'b0;
            v_ex_q     <= 1'b0;
            v_mem_q    <= 1'b0;
            v_wb_q     <= 1'b0;
            retired_q  <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            v_id_q     <= v_id_d;
            v_ex_q     <= v_ex_d;
            v_mem_q    <= v_mem_d;
            v_wb_q     <= v_wb_d;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
        end
    end

    assign v_id        = v_id_q;
    assign v_ex        = v_ex_q;
    assign v_mem       = v_mem_q;
    assign v_wb        = v_wb_q;
    assign halted      = halted_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

endmodule
